// File: rtl/mha_feeder.sv
// mha_feeder: streams a row-major frame buffer (N_TOK rows x D_MODEL words)
// into an MHA block over a valid/ready handshake, with a one-cycle init pulse
// before each frame.
// Optional feature: define MHA_FEED_CLS_EN to add a D_MODEL-word CLS row that
// is written with wr_cls=1 and sent ahead of the token rows in every frame.
module mha_feeder #(
  parameter int WIDTH   = 32,
  parameter int N_TOK   = 4,
  parameter int D_MODEL = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [$clog2(N_TOK*D_MODEL)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
`ifdef MHA_FEED_CLS_EN
  input  logic                              wr_cls,
`endif
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              mha_init,
  input  logic                              mha_ready,
  output logic                              mha_valid,
  output logic [WIDTH-1:0]                  mha_data
);

  localparam int DEPTH = N_TOK * D_MODEL;
  localparam int AW    = $clog2(DEPTH);
`ifdef MHA_FEED_CLS_EN
  localparam int CW    = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam int TOTAL = DEPTH + D_MODEL;
`else
  localparam int TOTAL = DEPTH;
`endif
  localparam int IW    = $clog2(TOTAL);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_RDY,
    STREAM,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0] buf_q [DEPTH];
`ifdef MHA_FEED_CLS_EN
  logic [WIDTH-1:0] cls_q [D_MODEL];
`endif
  logic [WIDTH-1:0] word;

  // Buffer write port, open only in IDLE so a running frame sees stable data.
  // NOTE: the buffers are plain storage with no reset; their contents are
  // undefined after reset and a reset branch would only cost a clear path.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
`ifdef MHA_FEED_CLS_EN
      if (wr_cls) begin
        cls_q[CW'(int'(wr_addr) % D_MODEL)] <= wr_data;
      end else begin
        buf_q[wr_addr] <= wr_data;
      end
`else
      buf_q[wr_addr] <= wr_data;
`endif
    end
  end

  // Select the word at the current stream index (CLS row first when enabled).
  always_comb begin
`ifdef MHA_FEED_CLS_EN
    if (idx_q < IW'(D_MODEL)) begin
      word = cls_q[CW'(idx_q)];
    end else begin
      word = buf_q[AW'(idx_q - IW'(D_MODEL))];
    end
`else
    word = buf_q[idx_q];
`endif
  end

  // State and stream index registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index logic; a word transfers when STREAM sees ready.
  // NOTE: defaults come first so every path assigns state_d and idx_d and no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      INIT:     state_d = WAIT_RDY;
      WAIT_RDY: if (mha_ready) state_d = STREAM;
      STREAM: begin
        if (mha_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mha_init  = (state_q == INIT);
  assign mha_valid = (state_q == STREAM);
  assign mha_data  = mha_valid ? word : '0;

endmodule

// File: tb/tb_mha_feeder.sv
// Self-checking bench for mha_feeder: a word-list model of the buffer and the
// handshake rules predicts every output cycle by cycle.
// Build with MHA_FEED_CLS_EN defined to exercise the CLS row.
module tb_mha_feeder;

  localparam int WIDTH   = 32;
  localparam int N_TOK   = 4;
  localparam int D_MODEL = 8;
  localparam int DEPTH   = N_TOK * D_MODEL;
  localparam int AW      = $clog2(DEPTH);
  localparam int BUDGET  = 2000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
`ifdef MHA_FEED_CLS_EN
  logic             wr_cls = 1'b0;
`endif
  logic             start = 1'b0;
  logic             mha_ready = 1'b0;
  logic             busy, done, mha_init, mha_valid;
  logic [WIDTH-1:0] mha_data;

  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] cls_m [D_MODEL];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mha_feeder #(.WIDTH(WIDTH), .N_TOK(N_TOK), .D_MODEL(D_MODEL)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef MHA_FEED_CLS_EN
    .wr_cls    (wr_cls),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mha_init  (mha_init),
    .mha_ready (mha_ready),
    .mha_valid (mha_valid),
    .mha_data  (mha_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_init"},  32'(mha_init),  32'd0);
    check({tag, "_valid"}, 32'(mha_valid), 32'd0);
    check({tag, "_data"},  mha_data,       32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the write edge.
  task automatic write_word(input bit cls, input int addr, input logic [WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
`ifdef MHA_FEED_CLS_EN
    wr_cls  = cls;
`endif
    if (cls) cls_m[addr % D_MODEL] = data;
    else     mem_m[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
`ifdef MHA_FEED_CLS_EN
    wr_cls = 1'b0;
`endif
  endtask

  task automatic load_default();
    for (int i = 0; i < DEPTH; i++) write_word(1'b0, i, WIDTH'(i + 1));
`ifdef MHA_FEED_CLS_EN
    // Addresses D_MODEL..2*D_MODEL-1 also land on CLS words 0..D_MODEL-1.
    for (int i = 0; i < D_MODEL; i++) write_word(1'b1, i + D_MODEL, WIDTH'(32'hC0 + i));
`endif
  endtask

  // mode 0: ready high, 1: toggling, 2: random, 3: low for 20 cycles after INIT.
  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 1;
      2:       return $urandom_range(0, 3) != 0;
      default: return c > 21;
    endcase
  endfunction

  // One frame: cycle 0 is the start cycle; cycle c is the c-th cycle after it.
  task automatic run_frame(input int mode, input int abort_at, input bit poke, input bit wr_at_start);
    logic [WIDTH-1:0] exp_q [$];
    int total;
    int nx = 0;
    int last_x = -1;
    int first_rdy = -1;
    int a;
    bit streaming, rdy, exp_done;
    bit finished = 1'b0;
    logic [WIDTH-1:0] d;

    start = 1'b1;
    mha_ready = 1'b0;
    if (wr_at_start) begin
      a = $urandom_range(0, DEPTH - 1);
      d = $urandom;
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      mem_m[a] = d;
    end
`ifdef MHA_FEED_CLS_EN
    for (int i = 0; i < D_MODEL; i++) exp_q.push_back(cls_m[i]);
`endif
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem_m[i]);
    total = exp_q.size();
    @(negedge clk);
    check("start_cycle_busy", 32'(busy), 32'd0);

    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      start   = poke && (c == 6);
      wr_en   = poke && (c == 6);
      wr_addr = '0;
      wr_data = WIDTH'(32'hDEAD);
      rdy = ready_for(mode, c);
      mha_ready = rdy;
      streaming = (first_rdy >= 0) && (c > first_rdy) && (nx < total);
      exp_done  = (last_x >= 0) && (c == last_x + 1);
      if (first_rdy < 0 && c >= 2 && rdy) first_rdy = c;
      @(negedge clk);
      check("init",  32'(mha_init),  32'(c == 1));
      check("busy",  32'(busy),      32'd1);
      check("valid", 32'(mha_valid), 32'(streaming));
      check("data",  mha_data,       streaming ? exp_q[nx] : '0);
      check("done",  32'(done),      32'(exp_done));
      if (streaming && rdy) begin
        nx++;
        if (abort_at > 0 && nx == abort_at) begin
          reset = 1'b1;
          #1;
          check_all_zero("abort");
          @(posedge clk); #1;
          check("abort_no_done", 32'(done), 32'd0);
          check("abort_idle",    32'(busy), 32'd0);
          reset = 1'b0;
          start = 1'b0;
          wr_en = 1'b0;
          return;
        end
        if (nx == total) last_x = c;
      end
      if (exp_done) begin
        finished = 1'b1;
        if (mode == 0) check("done_latency", 32'(c), 32'(3 + total));
        break;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      mha_ready = 1'($urandom);
      @(negedge clk);
      check("after_busy",  32'(busy),      32'd0);
      check("after_done",  32'(done),      32'd0);
      check("after_valid", 32'(mha_valid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    load_default();
    run_frame(0, 0, 1'b0, 1'b0);   // ready high: latency and order
    run_frame(1, 0, 1'b0, 1'b0);   // toggling ready: hold, no drop/dup
    run_frame(0, 0, 1'b1, 1'b0);   // start + write while busy are ignored
    run_frame(0, 0, 1'b0, 1'b0);   // word 0 still the original value
    run_frame(0, 10, 1'b0, 1'b0);  // reset on the 10th transfer
    load_default();
    run_frame(0, 0, 1'b0, 1'b0);   // full frame after abort
    run_frame(3, 0, 1'b0, 1'b0);   // long wait for ready

    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 8; w++) write_word(1'b0, $urandom_range(0, DEPTH - 1), $urandom);
`ifdef MHA_FEED_CLS_EN
      write_word(1'b1, $urandom_range(0, DEPTH - 1), $urandom);
`endif
      run_frame(2, 0, 1'b0, 1'b1); // random ready, write coincident with start
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mha_feeder.md
MHA_FEEDER -- requirements
Module: mha_feeder

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the bit width of every data word.
REQ-002 Parameter N_TOK, default 4, SHALL set the number of token rows streamed per frame.
REQ-003 Parameter D_MODEL, default 8, SHALL set the number of words per row.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL write wr_data into the frame buffer at wr_addr.
REQ-007 wr_addr  input  $clog2(N_TOK*D_MODEL)  SHALL be the row-major word address (row*D_MODEL+col).
REQ-008 wr_data  input  WIDTH  SHALL be the word to store.
REQ-009 start  input  1  SHALL request transmission of one frame.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 done  output  1  SHALL pulse high for one cycle when the last word of a frame transfers.
REQ-012 mha_init  output  1  SHALL drive the MHA init input.
REQ-013 mha_ready  input  1  SHALL be the MHA ready output.
REQ-014 mha_valid  output  1  SHALL mark mha_data as a valid word.
REQ-015 mha_data  output  WIDTH  SHALL drive the MHA input_block port.

Function
REQ-016 The FSM SHALL have states IDLE, INIT, WAIT_RDY, STREAM, DONE.
REQ-017 In IDLE, start=1 SHALL move to INIT; start=0 SHALL hold IDLE.
REQ-018 INIT SHALL last exactly one cycle with mha_init=1, then go to WAIT_RDY; mha_init SHALL be 0 in all other states.
REQ-019 WAIT_RDY SHALL move to STREAM on the first cycle mha_ready=1 is sampled.
REQ-020 In STREAM, mha_valid SHALL be 1 and mha_data SHALL equal buffer[idx]; a word transfers on a rising edge with mha_valid=1 and mha_ready=1, and idx then increments by 1.
REQ-021 With mha_ready=0 in STREAM, mha_data and idx SHALL hold unchanged (no word dropped or duplicated).
REQ-022 Words SHALL be sent in row-major order, idx 0 to N_TOK*D_MODEL-1; idx SHALL reset to 0 on entry to INIT.
REQ-023 The transfer of the final word SHALL move the FSM to DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-024 mha_valid SHALL be 0 and mha_data SHALL be 0 outside STREAM.
REQ-025 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 wr_en while busy=1 SHALL be ignored (buffer write-protected during a frame); wr_en in IDLE simultaneous with start SHALL complete the write before streaming begins.
REQ-027 A frame SHALL require N_TOK*D_MODEL transfer cycles; with mha_ready held high, done SHALL assert 3+N_TOK*D_MODEL cycles after the start cycle.

Reset
REQ-028 Asserting reset SHALL force IDLE, idx=0, busy=0, done=0, mha_init=0, mha_valid=0, mha_data=0, immediately and independent of clk.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; buffer contents need not be cleared and SHALL NOT be relied upon after reset.

Configuration
REQ-030 Macro MHA_FEED_CLS_EN defined SHALL add a D_MODEL-word CLS buffer and input wr_cls (1 bit); wr_en with wr_cls=1 SHALL write CLS word wr_addr mod D_MODEL.
REQ-031 With MHA_FEED_CLS_EN defined, each frame SHALL send the CLS row first and then the N_TOK token rows, i.e. (N_TOK+1)*D_MODEL words, done then asserting 3+(N_TOK+1)*D_MODEL cycles after start with ready held high.
REQ-032 With MHA_FEED_CLS_EN undefined, wr_cls and the CLS buffer SHALL NOT exist and frames SHALL be N_TOK*D_MODEL words.

Verification
REQ-033 Load buffer[i]=i+1 for i=0..31, pulse start, hold mha_ready=1 -> mha_init one cycle, then 32 words with values 1..32 in order, done at cycle 35 after start.
REQ-034 Same load, mha_ready toggling 1,0,1,0 -> each word appears exactly once in order, held stable while ready=0, and done after the 32nd transfer.
REQ-035 Pulse start again during STREAM and write wr_addr=0 with 0xDEAD -> no second frame, and the next frame still sends word 0 = 1.
REQ-036 Assert reset at the 10th transfer -> all outputs 0 immediately, no done pulse, and a later start sends a complete 32-word frame.
REQ-037 With MHA_FEED_CLS_EN, CLS words = 0xC0..0xC7 -> 40 words, the first eight being 0xC0..0xC7, done at cycle 43.
REQ-038 Keep mha_ready=0 for 20 cycles after INIT -> FSM stays in WAIT_RDY with mha_valid=0 and busy=1, and streaming begins on the first ready=1.
